// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule sequencer: drives a one-round key generator through all
// rounds, stores every round key, and serves them through a registered read port.
module aes_key_sched_ctrl #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_key_load,
    input  logic [127:0] i_cipher_key,
    input  logic         i_key_clear,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_keys_valid,
    output logic [127:0] kg_pre_rnd_key,
    output logic         kg_en,
    output logic [3:0]   kg_round_num,
    input  logic [127:0] kg_next_rnd_key,
    input  logic [3:0]   i_rk_rd_addr,
    output logic [127:0] o_rk_rd_data
);

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);
    localparam logic [3:0] MAX_ADDR = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, DONE} state_t;

    state_t                        state;
    logic [3:0]                    round;
    logic [127:0]                  work;
    logic [NUM_ROUNDS:0][127:0]    rk;

    assign kg_pre_rnd_key = work;

    // Clear shares the reset path so any in-flight CAPT write is simply dropped;
    // only a true reset forgets the last issued round number.
    always_ff @(posedge clk) begin
        if (rst || i_key_clear) begin
            state        <= IDLE;
            round        <= '0;
            work         <= '0;
            rk           <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_keys_valid <= 1'b0;
            kg_en        <= 1'b0;
            if (rst)
                kg_round_num <= '0;
        end else begin
            o_done <= 1'b0;
            kg_en  <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_key_load) begin
                        rk[0]        <= i_cipher_key;
                        work         <= i_cipher_key;
                        round        <= '0;
                        o_keys_valid <= 1'b0;
                        o_busy       <= 1'b1;
                        kg_en        <= 1'b1;
                        kg_round_num <= '0;
                        state        <= ISSUE;
                    end
                end
                ISSUE: state <= CAPT;
                CAPT: begin
                    rk[round + 4'd1] <= kg_next_rnd_key;
                    work             <= kg_next_rnd_key;
                    if (round == LAST_RND) begin
                        o_done <= 1'b1;
                        state  <= DONE;
                    end else begin
                        round        <= round + 4'd1;
                        kg_en        <= 1'b1;
                        kg_round_num <= round + 4'd1;
                        state        <= ISSUE;
                    end
                end
                DONE: begin
                    o_keys_valid <= 1'b1;
                    o_busy       <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            o_rk_rd_data <= '0;
        else if (i_rk_rd_addr <= MAX_ADDR)
            o_rk_rd_data <= rk[i_rk_rd_addr];
        else
            o_rk_rd_data <= '0;
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: behavioural key-generator stub, FIPS-197 word-level
// schedule reference, directed and random-key scenarios.
module tb_aes_key_sched_ctrl;

    localparam int N = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_key_load = 1'b0;
    logic [127:0] i_cipher_key = '0;
    logic         i_key_clear = 1'b0;
    logic         o_busy, o_done, o_keys_valid, kg_en;
    logic [127:0] kg_pre_rnd_key;
    logic [3:0]   kg_round_num;
    logic [127:0] kg_next_rnd_key = '0;
    logic [3:0]   i_rk_rd_addr = '0;
    logic [127:0] o_rk_rd_data;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox [256];
    logic [127:0] ref_rk [N+1];

    always #5 clk = ~clk;

    aes_key_sched_ctrl #(.NUM_ROUNDS(N)) dut (
        .clk(clk), .rst(rst), .i_key_load(i_key_load), .i_cipher_key(i_cipher_key),
        .i_key_clear(i_key_clear), .o_busy(o_busy), .o_done(o_done),
        .o_keys_valid(o_keys_valid), .kg_pre_rnd_key(kg_pre_rnd_key), .kg_en(kg_en),
        .kg_round_num(kg_round_num), .kg_next_rnd_key(kg_next_rnd_key),
        .i_rk_rd_addr(i_rk_rd_addr), .o_rk_rd_data(o_rk_rd_data)
    );

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [7:0] rcon(input int n);
        logic [7:0] x = 8'h01;
        for (int j = 0; j < n; j++) x = xtime(x);
        return x;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // One AES-128 round of key expansion, standing in for aes_key_gen.
    function automatic logic [127:0] next_key(input logic [127:0] k, input int r);
        logic [31:0] t, n0, n1, n2, n3;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rcon(r), 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    always @(posedge clk)
        if (kg_en) kg_next_rnd_key <= next_key(kg_pre_rnd_key, int'(kg_round_num));

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Full word-level FIPS-197 expansion w[0..43].
    task automatic build_ref(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i/4 - 1), 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= N; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"}, 128'(o_busy), 128'd0);
        chk({tag, " done"}, 128'(o_done), 128'd0);
        chk({tag, " valid"}, 128'(o_keys_valid), 128'd0);
        chk({tag, " kg_en"}, 128'(kg_en), 128'd0);
        chk({tag, " kg_rnd"}, 128'(kg_round_num), 128'd0);
        chk({tag, " kg_pre"}, kg_pre_rnd_key, 128'd0);
        chk({tag, " rd_data"}, o_rk_rd_data, 128'd0);
    endtask

    task automatic read_chk(input logic [3:0] addr, input logic [127:0] exp, input string tag);
        @(negedge clk);
        i_rk_rd_addr = addr;
        @(negedge clk);
        chk($sformatf("%s rd%0d", tag, addr), o_rk_rd_data, exp);
    endtask

    // Load a key and watch cycles 1..2N+2; optional extra load, clear or reset in a given cycle.
    task automatic run_exp(input logic [127:0] key, input int ld2_cyc, input int clr_cyc,
                           input int rst_cyc);
        @(negedge clk);
        i_cipher_key = key;
        i_key_load   = 1'b1;
        for (int c = 1; c <= 2*N + 2; c++) begin
            @(negedge clk);
            if (rst_cyc != 0 && c > rst_cyc) begin
                if (c == rst_cyc + 1) chk_all_zero($sformatf("rst c%0d", c));
                chk($sformatf("rst busy c%0d", c), 128'(o_busy), 128'd0);
            end else if (clr_cyc != 0 && c > clr_cyc) begin
                chk($sformatf("clr busy c%0d", c), 128'(o_busy), 128'd0);
                chk($sformatf("clr done c%0d", c), 128'(o_done), 128'd0);
                chk($sformatf("clr kg_en c%0d", c), 128'(kg_en), 128'd0);
                chk($sformatf("clr valid c%0d", c), 128'(o_keys_valid), 128'd0);
                chk($sformatf("clr work c%0d", c), kg_pre_rnd_key, 128'd0);
            end else begin
                logic en_exp;
                en_exp = (c % 2 == 1) && (c <= 2*N - 1);
                chk($sformatf("kg_en c%0d", c), 128'(kg_en), 128'(en_exp));
                chk($sformatf("busy c%0d", c), 128'(o_busy), 128'(c <= 2*N + 1));
                chk($sformatf("done c%0d", c), 128'(o_done), 128'(c == 2*N + 1));
                chk($sformatf("valid c%0d", c), 128'(o_keys_valid), 128'(c >= 2*N + 2));
                if (en_exp) begin
                    chk($sformatf("kg_rnd c%0d", c), 128'(kg_round_num), 128'((c - 1) / 2));
                    chk($sformatf("kg_pre c%0d", c), kg_pre_rnd_key, ref_rk[(c - 1) / 2]);
                end
            end
            i_key_load   = (c == ld2_cyc);
            i_cipher_key = (c == ld2_cyc) ? {128{1'b1}} : key;
            i_key_clear  = (c == clr_cyc);
            rst          = (c == rst_cyc);
        end
        i_key_load  = 1'b0;
        i_key_clear = 1'b0;
        rst         = 1'b0;
    endtask

    task automatic read_store(input string tag, input bit zero);
        for (int a = 0; a <= N; a++)
            read_chk(4'(a), zero ? 128'd0 : ref_rk[a], tag);
    endtask

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    initial begin
        build_sbox();

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // FIPS-197 A.1 vector with full handshake timing
        build_ref(FIPS_KEY);
        run_exp(FIPS_KEY, 0, 0, 0);
        read_store("fips", 1'b0);
        read_chk(4'd1, FIPS_RK1, "fips_const");
        read_chk(4'd10, FIPS_RK10, "fips_const");

        // Second load while busy is ignored
        run_exp(FIPS_KEY, 7, 0, 0);
        read_store("ld_busy", 1'b0);
        read_chk(4'd10, FIPS_RK10, "ld_busy_const");

        // Clear mid-expansion zeroises everything
        run_exp(FIPS_KEY, 0, 10, 0);
        for (int a = 0; a < 16; a++) read_chk(4'(a), 128'd0, "clr");
        chk("clr valid", 128'(o_keys_valid), 128'd0);

        // Key 0 after clear
        build_ref(128'd0);
        run_exp(128'd0, 0, 0, 0);
        read_store("key0", 1'b0);
        read_chk(4'd10, ZERO_RK10, "key0_const");

        // Simultaneous load + clear in IDLE: dropped load, store wiped
        @(negedge clk);
        i_cipher_key = {$urandom, $urandom, $urandom, $urandom};
        i_key_load   = 1'b1;
        i_key_clear  = 1'b1;
        @(negedge clk);
        i_key_load  = 1'b0;
        i_key_clear = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("ldclr busy %0d", c), 128'(o_busy), 128'd0);
            chk($sformatf("ldclr kg_en %0d", c), 128'(kg_en), 128'd0);
            chk($sformatf("ldclr valid %0d", c), 128'(o_keys_valid), 128'd0);
            @(negedge clk);
        end
        read_store("ldclr", 1'b1);

        // Random keys, random reads including out-of-range addresses
        for (int k = 0; k < 3; k++) begin
            logic [127:0] key;
            key = {$urandom, $urandom, $urandom, $urandom};
            build_ref(key);
            run_exp(key, 0, 0, 0);
            read_store($sformatf("rnd%0d", k), 1'b0);
            for (int j = 0; j < 6; j++) begin
                int a;
                a = $urandom_range(0, 15);
                read_chk(4'(a), (a <= N) ? ref_rk[a] : 128'd0, $sformatf("rnd%0d_rr", k));
            end
        end
        for (int a = N + 1; a < 16; a++) read_chk(4'(a), 128'd0, "oor");

        // Reset mid-expansion in cycle 15
        build_ref(FIPS_KEY);
        run_exp(FIPS_KEY, 0, 0, 15);
        read_store("post_rst", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
Controller that sequences the single-round AES-128 key-expansion datapath (aes_key_gen) through all rounds after a new cipher key is loaded. It captures each round key into an 11-entry round-key store and serves those keys to the cipher round engine through a registered read port. It exposes a start/busy/done handshake to the GCM top level and supports a clear that aborts expansion and zeroises stored key material.

Parameters:
NUM_ROUNDS, 10, rounds to expand; store depth = NUM_ROUNDS+1; legal range 1..10 (round_num and rcon table cover 0..9).

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
i_key_load  in  1  single-cycle start pulse; samples i_cipher_key
i_cipher_key  in  128  cipher key (round key 0)
i_key_clear  in  1  abort expansion and zeroise store
o_busy  out  1  high from the cycle after an accepted load through the DONE cycle inclusive
o_done  out  1  one-cycle pulse when all round keys are stored
o_keys_valid  out  1  store holds a complete, consistent schedule
kg_pre_rnd_key  out  128  to aes_key_gen pre_rnd_key
kg_en  out  1  to aes_key_gen i_en_key_gen
kg_round_num  out  4  to aes_key_gen round_num
kg_next_rnd_key  in  128  from aes_key_gen next_rnd_key (registered, 1-cycle latency)
i_rk_rd_addr  in  4  round-key read index 0..NUM_ROUNDS
o_rk_rd_data  out  128  registered read data

Behaviour:
- Reset (rst high at clock edge): state=IDLE; round counter=0; work key=0; all store entries=0; o_busy=0, o_done=0, o_keys_valid=0, kg_en=0, kg_round_num=0, kg_pre_rnd_key=0, o_rk_rd_data=0.
- FSM states: IDLE, ISSUE, CAPT, DONE.
- IDLE:
  - i_key_load=1: rk[0] <= i_cipher_key; work <= i_cipher_key; round <= 0; o_keys_valid <= 0; go to ISSUE.
- ISSUE:
  - kg_en=1, kg_round_num=round, kg_pre_rnd_key=work (combinational from registers).
  - Go to CAPT.
- CAPT:
  - kg_en=0; kg_next_rnd_key is valid in this cycle.
  - rk[round+1] <= kg_next_rnd_key; work <= kg_next_rnd_key.
  - If round==NUM_ROUNDS-1, go to DONE; otherwise round <= round+1 and go to ISSUE.
- DONE:
  - o_done=1 for this cycle only.
  - o_keys_valid <= 1; go to IDLE.
- Latency: load sampled at edge 0; ISSUE cycles 1,3,…,2N-1; CAPT cycles 2,4,…,2N; DONE cycle 2N+1. With N=10, o_done is asserted in cycle 21 and o_keys_valid is high from cycle 22.
- kg_en is never asserted outside ISSUE. kg_round_num holds its last value when kg_en=0; kg_pre_rnd_key always equals work.
- Read port:
  - o_rk_rd_data <= rk[i_rk_rd_addr] every cycle, 1-cycle latency.
  - Address > NUM_ROUNDS returns 0.
  - Reads during expansion are permitted and return current contents; consumers gate on o_keys_valid.
  - A write to the addressed entry in the same cycle returns the old value.
- i_key_load while not IDLE: ignored, with no effect on state, store or outputs.
- i_key_load in IDLE with o_keys_valid=1: accepted; o_keys_valid drops the next cycle and the schedule is rebuilt.
- i_key_clear, any state: next cycle state=IDLE, round=0, work=0, all rk=0, o_keys_valid=0, o_done=0. A pending CAPT write is discarded.
- i_key_clear with i_key_load in the same cycle: clear wins; load is dropped.
- rst has priority over everything.
- aes_key_gen carries its own reset. Expansion correctness does not depend on that reset, because work is presented before every kg_en assertion.

Test Plan:
- FIPS-197 A.1: load 2b7e151628aed2a6abf7158809cf4f3c -> o_done in cycle 21; rk[1]=a0fafe1788542cb123a339392a6c7605; rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6; read addr 10 returns that value one cycle later.
- Handshake timing: check kg_en high only in cycles 1,3,…,19, with kg_round_num=0..9 in order; o_busy high cycles 1..21; o_keys_valid rises in cycle 22.
- Load while busy: second i_key_load (key all-ones) in cycle 7 -> ignored; final schedule still matches vector 1.
- Clear mid-expansion: i_key_clear in cycle 10 -> cycle 11 IDLE, o_busy=0, o_done never pulses; all addresses read 0; o_keys_valid=0. A later load of key 0 gives rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
- Simultaneous load+clear in IDLE -> no expansion; o_busy stays 0; store stays 0.
- Out-of-range read addr 11..15 -> o_rk_rd_data=0; rst asserted in cycle 15 -> all outputs 0 next cycle.
